// File: rtl/iiitb_lifo_pkg.sv
// Shared constants and state encoding for the LIFO drain controller and its word buffer.
package iiitb_lifo_pkg;

  localparam int DW    = 4;
  localparam int PACK  = 2;
  localparam int DEPTH = 8;
  localparam int WW    = DW * PACK;
  localparam int PCW   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CMW   = $clog2(2 * PACK + 1) + 1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/iiitb_word_skid2.sv
// Two-entry valid/ready word buffer; words leave in arrival order and the head is held while stalled.
module iiitb_word_skid2
  import iiitb_lifo_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  input  logic [WW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [WW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    out_cnt
);

  logic [WW-1:0] mem [2];
  logic          push;
  logic          pop;

  assign in_ready  = (out_cnt != 2'd2);
  assign out_valid = (out_cnt != 2'd0);
  assign out_data  = mem[0];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: the entries are reset on purpose so a reset mid-drain leaves no stale word visible on out_data.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      out_cnt <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (out_cnt == 2'd0) mem[0] <= in_data;
          else                 mem[1] <= in_data;
          out_cnt <= out_cnt + 2'd1;
        end
        2'b01: begin
          mem[0]  <= mem[1];
          out_cnt <= out_cnt - 2'd1;
        end
        2'b11: mem[0] <= in_data;  // only reachable with exactly one entry held
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/iiitb_lifo_drain_ctrl.sv
// Owns the LIFO port: forwards pushes while idle, and on start pops the stack empty,
// packing popped nibbles MS-first into words on a valid/ready output.
module iiitb_lifo_drain_ctrl
  import iiitb_lifo_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          out_valid,
  output logic [WW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] pop_count,
  output logic [DW-1:0] lifo_dataIn,
  output logic          lifo_RW,
  output logic          lifo_EN,
  input  logic [DW-1:0] lifo_dataOut,
  input  logic          lifo_EMPTY,
  input  logic          lifo_FULL
);

  state_t           state;
  logic             inflight;
  logic [PCW-1:0]   pack_cnt;
  logic [WW-1:0]    pack_reg;
  logic [WW-1:0]    cap_word;
  logic [WW-1:0]    skid_data;
  logic [1:0]       out_cnt;
  logic [CMW-1:0]   committed;
  logic             do_push;
  logic             do_pop;
  logic             cap_last;
  logic             flush_push;
  logic             skid_valid;
  logic             skid_ready;

  assign wr_ready    = (state == ST_IDLE) & ~start & ~lifo_FULL;
  assign do_push     = wr_valid & wr_ready;

  // Words already owed downstream; popping stops once both buffer slots are spoken for.
  assign committed   = CMW'(out_cnt) * CMW'(PACK) + CMW'(pack_cnt) + CMW'(inflight);
  assign do_pop      = (state == ST_DRAIN) & ~lifo_EMPTY & (committed < CMW'(2 * PACK));

  assign lifo_EN     = do_push | do_pop;
  assign lifo_RW     = do_pop ? RW_READ : RW_WRITE;
  assign lifo_dataIn = wr_data;

  assign busy        = (state == ST_DRAIN) | (state == ST_FLUSH);
  assign done        = (state == ST_DONE);

  assign cap_word    = pack_reg | (WW'(lifo_dataOut) << (DW * (PACK - 1 - int'(pack_cnt))));
  assign cap_last    = inflight & (pack_cnt == PCW'(PACK - 1));
  assign flush_push  = (state == ST_FLUSH) & (pack_cnt != '0);
  assign skid_valid  = cap_last | flush_push;
  assign skid_data   = cap_last ? cap_word : pack_reg;

  iiitb_word_skid2 u_skid (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (skid_valid),
    .in_data   (skid_data),
    .in_ready  (skid_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_cnt   (out_cnt)
  );

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      inflight  <= 1'b0;
      pack_cnt  <= '0;
      pack_reg  <= '0;
      pop_count <= '0;
    end else begin
      inflight <= do_pop;

      if (inflight) begin
        if (cap_last) begin
          pack_reg <= '0;
          pack_cnt <= '0;
        end else begin
          pack_reg <= cap_word;
          pack_cnt <= pack_cnt + PCW'(1);
        end
      end else if (flush_push && skid_ready) begin
        pack_reg <= '0;
        pack_cnt <= '0;
      end

      if (do_pop && pop_count != CW'(DEPTH)) pop_count <= pop_count + CW'(1);

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_DRAIN;
            pop_count <= '0;
          end
        end
        ST_DRAIN: if (lifo_EMPTY && !inflight) state <= ST_FLUSH;
        ST_FLUSH: if (pack_cnt == '0 || skid_ready) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_lifo_drain_ctrl.sv
// Bench for the LIFO drain controller: behavioural LIFO, word scoreboard, directed scenarios.
module tb_iiitb_lifo_drain_ctrl;
  import iiitb_lifo_pkg::*;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          out_valid;
  logic [WW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] pop_count;
  logic [DW-1:0] lifo_dataIn;
  logic          lifo_RW;
  logic          lifo_EN;
  logic [DW-1:0] lifo_dataOut;
  logic          lifo_EMPTY;
  logic          lifo_FULL;

  int checks;
  int failures;
  int done_cnt;
  int pops_seen;

  logic [WW-1:0] exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [WW-1:0] exp_w;

  always #5 Clk = ~Clk;

  iiitb_lifo_drain_ctrl dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .pop_count    (pop_count),
    .lifo_dataIn  (lifo_dataIn),
    .lifo_RW      (lifo_RW),
    .lifo_EN      (lifo_EN),
    .lifo_dataOut (lifo_dataOut),
    .lifo_EMPTY   (lifo_EMPTY),
    .lifo_FULL    (lifo_FULL)
  );

  // Behavioural LIFO: read data appears after the pop edge, flags reflect the last edge.
  logic [DW-1:0] stk [DEPTH];
  int            sp;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sp           <= 0;
      lifo_dataOut <= '0;
    end else if (lifo_EN) begin
      if (lifo_RW && sp != 0) begin
        lifo_dataOut <= stk[sp-1];
        sp           <= sp - 1;
      end else if (!lifo_RW && sp != DEPTH) begin
        stk[sp] <= lifo_dataIn;
        sp      <= sp + 1;
      end
    end
  end

  assign lifo_EMPTY = (sp == 0);
  assign lifo_FULL  = (sp == DEPTH);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst) begin
      if (done) done_cnt++;
      if (lifo_EN && lifo_RW) pops_seen++;
      check("lifo_port_safe",
            32'(lifo_EN && ((lifo_RW && lifo_EMPTY) || (!lifo_RW && lifo_FULL))), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", 32'(out_data), 32'(exp_w));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_nib(input logic [DW-1:0] v);
    int n;
    n        = 0;
    wr_valid = 1'b1;
    wr_data  = v;
    @(negedge Clk);
    while (!wr_ready && n < 50) begin
      n++;
      @(negedge Clk);
    end
    check("push_ready", 32'(wr_ready), 1);
    if (wr_ready) model_q.push_back(v);
    tick();
    wr_valid = 1'b0;
  endtask

  // Expected words: stack contents in pop order, first popped nibble in the MS slot.
  task automatic queue_expected();
    int            n;
    logic [WW-1:0] w;
    n = 0;
    w = '0;
    while (model_q.size() > 0) begin
      w = w | (WW'(model_q.pop_back()) << (DW * (PACK - 1 - n)));
      n++;
      if (n == PACK) begin
        exp_q.push_back(w);
        w = '0;
        n = 0;
      end
    end
    if (n > 0) exp_q.push_back(w);
  endtask

  task automatic start_drain();
    queue_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("done_seen", 32'(done), 1);
    repeat (6) tick();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_busy"},      32'(busy),      0);
    check({pfx, "_done"},      32'(done),      0);
    check({pfx, "_out_valid"}, 32'(out_valid), 0);
    check({pfx, "_out_data"},  32'(out_data),  0);
    check({pfx, "_pop_count"}, 32'(pop_count), 0);
    check({pfx, "_lifo_EN"},   32'(lifo_EN),   0);
    check({pfx, "_lifo_RW"},   32'(lifo_RW),   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    done_cnt  = 0;
    pops_seen = 0;
    Rst       = 1'b1;
    start     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    out_ready = 1'b1;
    #12;
    check_reset_values("rst");
    Rst = 1'b0;
    tick();
    check("idle_wr_ready", 32'(wr_ready), 1);

    // Three pushes, drain into one full word and one zero-padded word.
    push_nib(4'h2);
    push_nib(4'h4);
    push_nib(4'h6);
    done_cnt = 0;
    start_drain();
    wait_done();
    check("t1_pop_count", 32'(pop_count), 3);
    check("t1_done_once", 32'(done_cnt), 1);
    check("t1_words_left", 32'(exp_q.size()), 0);
    check("t1_out_valid", 32'(out_valid), 0);

    // Drain of an empty LIFO: done exactly on the third edge, nothing popped.
    done_cnt  = 0;
    pops_seen = 0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    @(negedge Clk);
    check("empty_edge1_busy", 32'(busy), 1);
    check("empty_edge1_done", 32'(done), 0);
    @(negedge Clk);
    check("empty_edge2_done", 32'(done), 0);
    @(negedge Clk);
    check("empty_edge3_done", 32'(done), 1);
    repeat (4) tick();
    check("empty_pops", 32'(pops_seen), 0);
    check("empty_out_valid", 32'(out_valid), 0);
    check("empty_pop_count", 32'(pop_count), 0);
    check("empty_done_once", 32'(done_cnt), 1);

    // Fill to FULL; ready falls with FULL and an extra write is held off.
    for (int i = 1; i <= DEPTH; i++) push_nib(DW'(i));
    check("full_flag", 32'(lifo_FULL), 1);
    check("full_wr_ready", 32'(wr_ready), 0);
    wr_valid = 1'b1;
    wr_data  = 4'h9;
    @(negedge Clk);
    check("full_pending_ready", 32'(wr_ready), 0);
    check("full_pending_en", 32'(lifo_EN), 0);
    tick();
    @(negedge Clk);
    check("full_pending_en2", 32'(lifo_EN), 0);
    tick();
    wr_valid = 1'b0;

    // Drain the full LIFO with downstream stalled, then release.
    out_ready = 1'b0;
    pops_seen = 0;
    done_cnt  = 0;
    start_drain();
    repeat (20) tick();
    check("stall_pops", 32'(pops_seen), 4);
    check("stall_out_valid", 32'(out_valid), 1);
    check("stall_busy", 32'(busy), 1);
    check("stall_head", 32'(out_data), 32'(exp_q[0]));
    out_ready = 1'b1;
    wait_done();
    check("stall_words_left", 32'(exp_q.size()), 0);
    check("stall_pop_count", 32'(pop_count), DEPTH);
    check("stall_done_once", 32'(done_cnt), 1);

    // start and wr_valid together: start wins, the write is dropped.
    push_nib(4'hA);
    push_nib(4'hB);
    push_nib(4'hC);
    done_cnt = 0;
    queue_expected();
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 4'hF;
    @(negedge Clk);
    check("race_wr_ready", 32'(wr_ready), 0);
    check("race_lifo_en", 32'(lifo_EN), 0);
    tick();
    start    = 1'b0;
    wr_valid = 1'b0;
    wait_done();
    check("race_pop_count", 32'(pop_count), 3);
    check("race_words_left", 32'(exp_q.size()), 0);
    check("race_done_once", 32'(done_cnt), 1);

    // Reset in the middle of a drain with a pop in flight.
    push_nib(4'h3);
    push_nib(4'h5);
    push_nib(4'h7);
    push_nib(4'h9);
    push_nib(4'hB);
    out_ready = 1'b0;
    done_cnt  = 0;
    start_drain();
    tick();
    check("mid_busy", 32'(busy), 1);
    #2;
    Rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    exp_q.delete();
    model_q.delete();
    tick();
    Rst       = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    check("mid_no_done", 32'(done_cnt), 0);
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_busy_after", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
